// File: rtl/m68k_bus_ctrl_if.sv
// Bus bundle between the 68000 CPU side and the bus-cycle controller.
// Carries the strobes, the address and the responses driven back to the CPU.
interface m68k_bus_ctrl_if;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw_n;
    logic [23:1] addr;
    logic        vga_ready;
    logic        rom_cs;
    logic        ram_cs;
    logic        vga_cs;
    logic        per_cs;
    logic [1:0]  ram_we;
    logic        dtack_n;
    logic        vpa_n;
    logic        berr_n;

    modport master (
        output as_n, uds_n, lds_n, rw_n, addr, vga_ready,
        input  rom_cs, ram_cs, vga_cs, per_cs, ram_we, dtack_n, vpa_n, berr_n
    );

    modport slave (
        input  as_n, uds_n, lds_n, rw_n, addr, vga_ready,
        output rom_cs, ram_cs, vga_cs, per_cs, ram_we, dtack_n, vpa_n, berr_n
    );
endinterface

// File: rtl/m68k_bus_ctrl.sv
// Bus-cycle controller for fx68k: region decode, wait states, VGA ready,
// VPA handshake for the peripheral window and bus-error timeout.
module m68k_bus_ctrl #(
    parameter int unsigned ROM_WAIT     = 1,
    parameter int unsigned RAM_WAIT     = 0,
    parameter int unsigned BERR_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    m68k_bus_ctrl_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_PERI, ST_ERR} state_t;
    typedef enum logic [2:0] {RG_NONE, RG_ROM, RG_RAM, RG_VGA, RG_PER} region_t;

    localparam logic [3:0] ROM_W    = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_W    = 4'(RAM_WAIT);
    localparam logic [7:0] TMO_LAST = 8'(BERR_TIMEOUT - 1);

    state_t      state, state_d;
    region_t     region, region_d, decoded;
    logic [3:0]  wait_cnt, wait_d;
    logic [7:0]  tmo_cnt, tmo_d;
    logic [1:0]  lanes, lanes_d;
    logic        is_write, write_d;
    logic        vga_ready_q;
    logic        start, wait_done, we_pulse;

    wire unused_addr = &{1'b0, bus.addr[15:1]};

    always_comb begin
        decoded = RG_NONE;
        if (bus.addr[23:16] == 8'h00)
            decoded = RG_ROM;
        else if (bus.addr[23:16] == 8'h10)
            decoded = RG_RAM;
        else if (bus.addr[23:16] == 8'h20)
            decoded = RG_VGA;
        else if (bus.addr[23:20] == 4'h6)
            decoded = RG_PER;
    end

    // Unmapped accesses never satisfy wait_done, so only the timeout ends them.
    always_comb begin
        state_d   = state;
        region_d  = region;
        wait_d    = wait_cnt;
        tmo_d     = tmo_cnt;
        lanes_d   = lanes;
        write_d   = is_write;
        we_pulse  = 1'b0;
        start     = !bus.as_n && (!bus.uds_n || !bus.lds_n);
        wait_done = (wait_cnt == 4'd0) && (region != RG_NONE)
                    && ((region != RG_VGA) || vga_ready_q);
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    region_d = decoded;
                    lanes_d  = {!bus.uds_n, !bus.lds_n};
                    write_d  = !bus.rw_n;
                    tmo_d    = 8'd0;
                    wait_d   = 4'd0;
                    state_d  = ST_WAIT;
                    case (decoded)
                        RG_ROM:  wait_d  = ROM_W;
                        RG_RAM:  wait_d  = RAM_W;
                        RG_PER:  state_d = ST_PERI;
                        default: wait_d  = 4'd0;
                    endcase
                end
            end
            ST_WAIT: begin
                if (bus.as_n) begin
                    state_d = ST_IDLE;
                end else if (wait_done) begin
                    state_d  = ST_ACK;
                    we_pulse = (region == RG_RAM) && is_write;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_cnt + 8'd1;
                    if (wait_cnt != 4'd0)
                        wait_d = wait_cnt - 4'd1;
                end
            end
            ST_ACK, ST_PERI, ST_ERR: begin
                if (bus.as_n)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            region      <= RG_NONE;
            wait_cnt    <= 4'd0;
            tmo_cnt     <= 8'd0;
            lanes       <= 2'b00;
            is_write    <= 1'b0;
            vga_ready_q <= 1'b0;
            bus.rom_cs  <= 1'b0;
            bus.ram_cs  <= 1'b0;
            bus.vga_cs  <= 1'b0;
            bus.per_cs  <= 1'b0;
            bus.ram_we  <= 2'b00;
            bus.dtack_n <= 1'b1;
            bus.vpa_n   <= 1'b1;
            bus.berr_n  <= 1'b1;
        end else begin
            state       <= state_d;
            region      <= region_d;
            wait_cnt    <= wait_d;
            tmo_cnt     <= tmo_d;
            lanes       <= lanes_d;
            is_write    <= write_d;
            vga_ready_q <= bus.vga_ready;
            bus.rom_cs  <= (state_d != ST_IDLE) && (region_d == RG_ROM);
            bus.ram_cs  <= (state_d != ST_IDLE) && (region_d == RG_RAM);
            bus.vga_cs  <= (state_d != ST_IDLE) && (region_d == RG_VGA);
            bus.per_cs  <= (state_d != ST_IDLE) && (region_d == RG_PER);
            bus.ram_we  <= we_pulse ? lanes : 2'b00;
            bus.dtack_n <= (state_d != ST_ACK);
            bus.vpa_n   <= (state_d != ST_PERI);
            bus.berr_n  <= (state_d != ST_ERR);
        end
    end
endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Randomized bench for m68k_bus_ctrl: each bus cycle is predicted from the
// region map and the wait/ready/timeout rules, then compared edge by edge.
module tb_m68k_bus_ctrl;
    localparam int ROM_WAIT     = 1;
    localparam int RAM_WAIT     = 0;
    localparam int BERR_TIMEOUT = 64;
    localparam logic [8:0] INACTIVE = 9'b0000_00_111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    m68k_bus_ctrl_if bus();

    m68k_bus_ctrl #(
        .ROM_WAIT(ROM_WAIT),
        .RAM_WAIT(RAM_WAIT),
        .BERR_TIMEOUT(BERR_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #20 clk = ~clk;

    wire [8:0] obs = {bus.rom_cs, bus.ram_cs, bus.vga_cs, bus.per_cs,
                      bus.ram_we, bus.dtack_n, bus.vpa_n, bus.berr_n};

    task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%b expected=%b (cs4,we2,dtack,vpa,berr)", tag, got, exp);
        end
    endtask

    // kind: 0 unmapped, 1 ROM, 2 RAM, 3 VGA, 4 peripheral.
    // ready_at: first edge index (from cycle start) at which vga_ready is high.
    task automatic applyStimulus(input string name, input logic [23:0] byte_addr,
                                 input logic uds, input logic lds, input logic rw,
                                 input int hold, input int ready_at);
        int         kind;
        int         n_ack;
        int         n_err;
        logic       started;
        logic [7:0] page;
        logic [8:0] exp;
        logic [22:0] rnd;

        page    = byte_addr[23:16];
        started = !(uds && lds);
        if (page == 8'h00)          kind = 1;
        else if (page == 8'h10)     kind = 2;
        else if (page == 8'h20)     kind = 3;
        else if (page >= 8'h60 && page <= 8'h6F) kind = 4;
        else                        kind = 0;

        n_ack = -1;
        n_err = -1;
        if (kind == 1) n_ack = 1 + ROM_WAIT;
        if (kind == 2) n_ack = 1 + RAM_WAIT;
        if (kind == 3) n_ack = (ready_at + 1 > 1) ? ready_at + 1 : 1;
        if (kind != 4 && (n_ack < 0 || n_ack > BERR_TIMEOUT)) begin
            n_ack = -1;
            n_err = BERR_TIMEOUT;
        end

        @(negedge clk);
        bus.as_n      = 1'b0;
        bus.uds_n     = uds;
        bus.lds_n     = lds;
        bus.rw_n      = rw;
        bus.addr      = byte_addr[23:1];
        bus.vga_ready = (ready_at <= 0);
        for (int n = 0; n <= hold; n++) begin
            @(negedge clk);
            exp = INACTIVE;
            if (started && n < hold) begin
                exp[8] = (kind == 1);
                exp[7] = (kind == 2);
                exp[6] = (kind == 3);
                exp[5] = (kind == 4);
                if (n_ack >= 0 && n >= n_ack) exp[2] = 1'b0;
                if (n_err >= 0 && n >= n_err) exp[0] = 1'b0;
                if (kind == 4) exp[1] = 1'b0;
                if (kind == 2 && !rw && n == n_ack) exp[4:3] = {!uds, !lds};
            end
            checkOutput($sformatf("%s n=%0d", name, n), obs, exp);
            rnd           = 23'($urandom);
            bus.addr      = rnd;
            bus.vga_ready = (n + 1 >= ready_at);
            if (n == hold - 1) bus.as_n = 1'b1;
        end
    endtask

    initial begin
        logic [23:0] a;
        logic        u, l;
        int          pick;
        bus.as_n      = 1'b1;
        bus.uds_n     = 1'b1;
        bus.lds_n     = 1'b1;
        bus.rw_n      = 1'b1;
        bus.addr      = '0;
        bus.vga_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_values", obs, INACTIVE);
        rst_n = 1'b1;

        // Reset arriving while a ROM read is being acknowledged.
        @(negedge clk);
        bus.as_n  = 1'b0;
        bus.uds_n = 1'b0;
        bus.lds_n = 1'b0;
        bus.rw_n  = 1'b1;
        bus.addr  = 23'h000080;
        repeat (3) @(negedge clk);
        checkOutput("rom_ack_before_reset", obs, 9'b1000_00_011);
        #5 rst_n = 1'b0;
        #1 checkOutput("async_reset_mid_ack", obs, INACTIVE);
        bus.as_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rom_after_reset", 24'h000100, 1'b0, 1'b0, 1'b1, 4, 0);

        applyStimulus("rom_read",        24'h000100, 1'b0, 1'b0, 1'b1, 6, 0);
        applyStimulus("ram_byte_write",  24'h100003, 1'b1, 1'b0, 1'b0, 5, 0);
        applyStimulus("ram_word_write",  24'h10F000, 1'b0, 1'b0, 1'b0, 4, 0);
        applyStimulus("vga_ready_late",  24'h200010, 1'b0, 1'b0, 1'b1, 12, 5);
        applyStimulus("vga_ready_tmo",   24'h200020, 1'b0, 1'b0, 1'b1, 70, BERR_TIMEOUT - 1);
        applyStimulus("vga_ready_miss",  24'h200020, 1'b0, 1'b0, 1'b1, 70, BERR_TIMEOUT);
        applyStimulus("peripheral",      24'h600000, 1'b0, 1'b1, 1'b1, 30, 0);
        applyStimulus("unmapped_berr",   24'h400000, 1'b0, 1'b0, 1'b1, 70, 0);
        applyStimulus("unmapped_abort",  24'h400000, 1'b0, 1'b0, 1'b1, 10, 0);
        applyStimulus("no_strobes",      24'h000100, 1'b1, 1'b1, 1'b1, 5, 0);

        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 5);
            a    = 24'($urandom);
            case (pick)
                0: a[23:16] = 8'h00;
                1: a[23:16] = 8'h10;
                2: a[23:16] = 8'h20;
                3: a[23:16] = 8'h60 + 8'($urandom_range(0, 15));
                default: ;
            endcase
            u = 1'($urandom);
            l = 1'($urandom);
            if ($urandom_range(0, 3) != 0 && u && l) l = 1'b0;
            applyStimulus($sformatf("rand%0d", i), a, u, l, 1'($urandom),
                          $urandom_range(1, 80), $urandom_range(0, 80));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m68k_bus_ctrl.md
# m68k_bus_ctrl

Bus-cycle controller for the fx68k CPU: decodes the 68000 address/strobe bus into chip selects and sequences every bus cycle. Per region it applies programmable wait states, a ready handshake for the video slave, the VPA handshake for the 6800-style peripheral window (ACIA, audio, keyboard) and a bus-error timeout for unmapped or hung accesses. It sits between the CPU's ASn/UDSn/LDSn/eRWn/eab outputs and the ROM, RAM, VGA and peripheral blocks, and drives DTACKn/VPAn/BERRn back into the CPU.

## Interface
Parameters:
- ROM_WAIT, 1, extra clk cycles before DTACK for ROM (0..15)
- RAM_WAIT, 0, extra clk cycles before DTACK for RAM (0..15)
- BERR_TIMEOUT, 64, clk cycles from cycle start to BERR when unacknowledged (2..255)

Ports:
- clk  in  1  system clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- as_n  in  1  CPU address strobe
- uds_n, lds_n  in  1 each  CPU upper/lower data strobes
- rw_n  in  1  1 = read, 0 = write
- addr  in  23  CPU address [23:1]
- vga_ready  in  1  VGA slave ready for current access
- rom_cs, ram_cs, vga_cs, per_cs  out  1 each  registered region selects
- ram_we  out  2  byte-lane write pulse {upper, lower}
- dtack_n  out  1  data transfer acknowledge
- vpa_n  out  1  valid peripheral address
- berr_n  out  1  bus error

## Operation
- Map on addr[23:16]: 0x00 ROM; 0x10 RAM; 0x20 VGA; 0x60–0x6F peripheral; all else unmapped.
- States: IDLE, WAIT, ACK, PERI, ERR.
- IDLE: as_n low and (uds_n low or lds_n low) sampled → latch region, assert the matching cs and load wait counter:
  - ROM → WAIT with ROM_WAIT.
  - RAM → WAIT with RAM_WAIT.
  - VGA → WAIT with 0.
  - Peripheral → PERI.
  - Unmapped → WAIT with no exit except timeout.
- WAIT: counter decrements each clk. Exit to ACK when the counter is 0, except VGA, which exits when counter is 0 and vga_ready = 1.
- ACK: dtack_n low, held until as_n sampled high.
- PERI: vpa_n low, held until as_n sampled high. dtack_n stays high; the CPU's E-clock logic completes the cycle.
- Timeout counter: 8-bit, cleared on IDLE exit, increments in WAIT. Reaching BERR_TIMEOUT → ERR (berr_n low, held until as_n high). PERI is exempt.
- as_n sampled high in any non-IDLE state → IDLE next clk; all cs, dtack_n, vpa_n and berr_n go inactive. This covers cycle abort mid-WAIT.
- ram_we: one-clk pulse on the WAIT→ACK transition, only for RAM with rw_n = 0. Bit1 = !uds_n, bit0 = !lds_n as sampled at cycle start.
- Region, rw_n and strobes are latched at cycle start; addr changes mid-cycle are ignored.
- Simultaneous timeout and ready in the same clk: ACK wins.
- A new cycle is recognised only from IDLE: as_n must be seen high for at least one clk between cycles.

## Timing
- All outputs registered.
- Reset values: cs = 0, ram_we = 0, dtack_n = 1, vpa_n = 1, berr_n = 1, state IDLE, counters 0. Async assert; outputs are inactive within the reset cycle.
- as_n low sampled at edge k → cs high after edge k.
- dtack_n low after edge k+1+W, with W = ROM_WAIT or RAM_WAIT. VGA: dtack_n low one edge after the first edge at which vga_ready is sampled high.
- vpa_n low after edge k.
- berr_n low after edge k+BERR_TIMEOUT.
- Release: as_n high sampled at edge m → all outputs inactive after edge m.

## Test plan
- Reset asserted mid-ACK on a ROM read → dtack_n = 1 and rom_cs = 0 immediately. After release, the next cycle starts fresh from IDLE.
- ROM read at 0x000100, ROM_WAIT = 1 → rom_cs high at k+1, dtack_n low at k+2, held until as_n high, then released the next clk.
- RAM byte write at 0x100003 (uds_n = 1, lds_n = 0, rw_n = 0), RAM_WAIT = 0 → dtack_n low at k+1, ram_we = 2'b01 for exactly one clk.
- VGA read with vga_ready low for 5 clks → dtack_n stays high; it goes low one clk after vga_ready rises. Also drive vga_ready high in the same clk the timeout fires → ACK, berr_n stays 1.
- Peripheral access at 0x600000 held for 30 clks → vpa_n low from k+1, dtack_n and berr_n stay 1 throughout.
- Unmapped read at 0x400000, BERR_TIMEOUT = 64 → berr_n low at k+64, dtack_n never low. A second case raises as_n at k+10 → WAIT aborts to IDLE with no BERR.
